// File: rtl/y_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package y_mul_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/y_mul_seq_if.sv
// Operand/result handshake bundle between the multiplier and its client.
interface y_mul_seq_if
    import y_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic               start_valid;
    logic               start_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               result_valid;
    logic               result_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start_valid, a, b, result_ready,
        input  start_ready, busy, result_valid, product
    );

    modport slave (
        input  start_valid, a, b, result_ready,
        output start_ready, busy, result_valid, product
    );
endinterface

// File: rtl/y_mul_seq_adder.sv
// Width-generic ripple-carry adder shared by the multiplier datapath.
module y_mul_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/y_mul_seq.sv
// Sequential unsigned shift-add multiplier, one adder pass per cycle.
// Optional early termination on exhausted multiplier bits: Y_MUL_SEQ_EARLY_TERM_EN.
//   state   | meaning
//   IDLE    | accept operands
//   RUN     | one shift-add iteration per cycle
//   DONE    | product presented until consumed
module y_mul_seq
    import y_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic      clk,
    input  logic      reset,
    y_mul_seq_if.slave bus
);
    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_final;
    logic               done_now;
    logic               accept;

    assign add_y = acc_lo[0] ? mcand : '0;

    y_mul_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (acc_hi),
        .y    (add_y),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry-out is shifted into the MSB so no product bit is lost.
    assign acc_next = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

`ifdef Y_MUL_SEQ_EARLY_TERM_EN
    logic [CNT_W-1:0] shift_amt;
    logic [WIDTH-1:0] rem_mask;

    // After this iteration the low shift_amt bits of acc_lo are still multiplier bits.
    assign shift_amt  = CNT_W'(WIDTH - 1) - cnt;
    assign rem_mask   = ~({WIDTH{1'b1}} << shift_amt);
    assign done_now   = (acc_next[WIDTH-1:0] & rem_mask) == '0;
    assign prod_final = acc_next >> shift_amt;
`else
    assign done_now   = (cnt == CNT_W'(WIDTH - 1));
    assign prod_final = acc_next;
`endif

    assign accept = (state == ST_IDLE) && bus.start_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start_valid)  state_next = ST_RUN;
            ST_RUN:  if (done_now)         state_next = ST_DONE;
            ST_DONE: if (bus.result_ready) state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            {acc_hi, acc_lo} <= acc_next;
            cnt              <= cnt + CNT_W'(1);
            if (done_now) begin
                product_q <= prod_final;
            end
        end
    end

    assign bus.start_ready  = (state == ST_IDLE);
    assign bus.busy         = (state == ST_RUN) || (state == ST_DONE);
    assign bus.result_valid = (state == ST_DONE);
    assign bus.product      = product_q;
endmodule

// File: tb/tb_y_mul_seq.sv
// Directed self-checking bench for y_mul_seq (WIDTH=32).
module tb_y_mul_seq;
    import y_mul_pkg::*;

`ifdef Y_MUL_SEQ_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    y_mul_seq_if #(.WIDTH(32)) bus ();

    y_mul_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.a           = a;
        bus.b           = b;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit timeout);
        lat     = 0;
        timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.result_valid) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({bus.start_ready, bus.busy, bus.result_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 100", {bus.start_ready, bus.busy, bus.result_valid});
        end
        n_cmp++;
        if (bus.product !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_product: got %h want 0", bus.product);
        end
    endtask

    task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_p, input int exp_lat);
        int lat;
        bit to;
        start_op(a, b);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_accept: busy=%b start_ready=%b want 1/0", name, bus.busy, bus.start_ready);
        end
        wait_valid(lat, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s_timeout: result_valid never rose", name);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (bus.product !== exp_p) begin
            n_bad++;
            $display("FAIL %s_product: got %h want %h", name, bus.product, exp_p);
        end
        consume();
        n_cmp++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_release: start_ready=%b result_valid=%b want 1/0", name, bus.start_ready, bus.result_valid);
        end
    endtask

    task automatic test_hold();
        int lat;
        bit to;
        start_op(32'h0001_0000, 32'h0001_0000);
        wait_valid(lat, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL hold_timeout: result_valid never rose");
        end
        for (int i = 0; i < 10; i++) begin
            bus.start_valid = i[0];
            bus.a           = 32'hDEAD_BEEF;
            bus.b           = 32'h1111_1111;
            @(posedge clk); #1;
            n_cmp++;
            if (bus.result_valid !== 1'b1 || bus.start_ready !== 1'b0 || bus.product !== 64'h0000_0001_0000_0000) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: valid=%b start_ready=%b product=%h want 1/0/0000000100000000",
                         i, bus.result_valid, bus.start_ready, bus.product);
            end
        end
        bus.start_valid = 1'b0;
        consume();
        n_cmp++;
        if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1 || bus.product !== 64'h0000_0001_0000_0000) begin
            n_bad++;
            $display("FAIL hold_release: valid=%b start_ready=%b product=%h want 0/1/0000000100000000",
                     bus.result_valid, bus.start_ready, bus.product);
        end
    endtask

    task automatic test_abort();
        start_op(32'd7, 32'd9);
        repeat (ET ? 2 : 16) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_inflight: busy=%b valid=%b want 1/0", bus.busy, bus.result_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if ({bus.start_ready, bus.busy, bus.result_valid} !== 3'b100 || bus.product !== 64'h0) begin
            n_bad++;
            $display("FAIL abort_reset: flags=%b product=%h want 100/0",
                     {bus.start_ready, bus.busy, bus.result_valid}, bus.product);
        end
        test_mul("abort_rerun", 32'd7, 32'd9, 64'd63, ET ? 4 : 32);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        bus.a           = 32'd2;
        bus.b           = 32'd3;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'd4;
        bus.b = 32'd5;
        wait_valid(lat, to);
        n_cmp++;
        if (to || lat !== (ET ? 2 : 32) || bus.product !== 64'd6) begin
            n_bad++;
            $display("FAIL b2b_first: timeout=%b lat=%0d product=%h want 0/%0d/6", to, lat, bus.product, ET ? 2 : 32);
        end
        consume();
        n_cmp++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle_gap: start_ready=%b busy=%b want 1/0", bus.start_ready, bus.busy);
        end
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_accept: busy=%b want 1", bus.busy);
        end
        wait_valid(lat, to);
        n_cmp++;
        if (to || lat !== (ET ? 3 : 32) || bus.product !== 64'd20) begin
            n_bad++;
            $display("FAIL b2b_second: timeout=%b lat=%0d product=%h want 0/%0d/14", to, lat, bus.product, ET ? 3 : 32);
        end
        consume();
    endtask

    initial begin
        n_cmp            = 0;
        n_bad            = 0;
        reset            = 1'b1;
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.a            = '0;
        bus.b            = '0;
        test_reset();
        test_mul("basic_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, ET ? 3 : 32);
        test_mul("max_ops", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
        test_hold();
        test_abort();
        test_back_to_back();
        test_mul("zero_a", 32'h0, 32'h8000_0000, 64'h0, 32);
        test_mul("zero_b", 32'h1234_5678, 32'h0, 64'h0, ET ? 1 : 32);
        test_mul("mixed", 32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800, ET ? 9 : 32);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
